// File: rtl/alu_arb_pkg.sv
// Shared op encoding and sizing for the ALU issue arbiter.
// Consumers: rr_arb2 and alu_issue_arbiter (optional macro ALU_ARB_FIXED_PRIO_EN).
package alu_arb_pkg;

    localparam int NUM_REQ  = 2;
    localparam int OP_W     = 4;
    localparam int NUM_CTRL = 10;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_AND  = 4'd2;
    localparam logic [OP_W-1:0] OP_OR   = 4'd3;
    localparam logic [OP_W-1:0] OP_SLL  = 4'd4;
    localparam logic [OP_W-1:0] OP_SRA  = 4'd5;
    localparam logic [OP_W-1:0] OP_ADDI = 4'd6;
    localparam logic [OP_W-1:0] OP_LW   = 4'd7;
    localparam logic [OP_W-1:0] OP_SW   = 4'd8;
    localparam logic [OP_W-1:0] OP_BR   = 4'd9;

    // Every code at or above this value has no ALU control line.
    localparam logic [OP_W-1:0] OP_ILLEGAL_MIN = 4'd10;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return op < OP_ILLEGAL_MIN;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant logic with an accept-updated last_grant register.
// ALU_ARB_FIXED_PRIO_EN selects strict port-0 priority (last_grant unused).
module rr_arb2
    import alu_arb_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               accept,
    output logic [NUM_REQ-1:0] grant
);

`ifdef ALU_ARB_FIXED_PRIO_EN

    logic unused_arb;
    assign unused_arb = ^{clk, reset, accept};

    always_comb begin
        grant = '0;
        if (req[0]) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end
    end

`else

    logic last_grant_q;
    logic last_grant_d;

    // On a tie the port that did not win last time goes first.
    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = grant[1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

`endif

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one combinational ALU between two requesters: arbitrate, issue (S1), respond (S2).
// Build option ALU_ARB_FIXED_PRIO_EN gives port 0 strict priority.
module alu_issue_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = alu_arb_pkg::OP_W,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [TAG_W-1:0]  req0_tag,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [TAG_W-1:0]  req1_tag,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_add,
    output logic              alu_sub,
    output logic              alu_addi,
    output logic              alu_and,
    output logic              alu_or,
    output logic              alu_sll,
    output logic              alu_sra,
    output logic              alu_sw,
    output logic              alu_lw,
    output logic              alu_br,
    input  logic [DATA_W-1:0] alu_result,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
);

    logic              s1_valid_q, s1_valid_d;
    logic [OP_W-1:0]   s1_op_q,    s1_op_d;
    logic              s1_id_q,    s1_id_d;
    logic [TAG_W-1:0]  s1_tag_q,   s1_tag_d;
    logic [DATA_W-1:0] s1_a_q,     s1_a_d;
    logic [DATA_W-1:0] s1_b_q,     s1_b_d;

    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q,    rsp_id_d;
    logic [TAG_W-1:0]  rsp_tag_q,   rsp_tag_d;
    logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
    logic              rsp_err_q,   rsp_err_d;

    logic               s2_free;
    logic               s1_free;
    logic               s1_adv;
    logic [NUM_REQ-1:0] req_vld;
    logic [NUM_REQ-1:0] grant;
    logic               acc0;
    logic               acc1;
    logic               accept;

    assign s2_free = !rsp_valid_q || rsp_ready;
    assign s1_adv  = s1_valid_q && s2_free;
    assign s1_free = !s1_valid_q || s2_free;

    assign req_vld    = {req1_valid, req0_valid};
    assign req0_ready = grant[0] && s1_free;
    assign req1_ready = grant[1] && s1_free;
    assign acc0       = req0_valid && req0_ready;
    assign acc1       = req1_valid && req1_ready;
    assign accept     = acc0 || acc1;

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req_vld),
        .accept (accept),
        .grant  (grant)
    );

    // Issue stage: a new accept overrides the clear from advancing.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_id_d    = s1_id_q;
        s1_tag_d   = s1_tag_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_id_d    = acc1;
            s1_op_d    = acc1 ? req1_op  : req0_op;
            s1_tag_d   = acc1 ? req1_tag : req0_tag;
            s1_a_d     = acc1 ? req1_a   : req0_a;
            s1_b_d     = acc1 ? req1_b   : req0_b;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // Illegal ops never sample the ALU: its output is stale when no control fires.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        if (s1_adv) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = s1_id_q;
            rsp_tag_d   = s1_tag_q;
            rsp_err_d   = !op_legal(s1_op_q);
            rsp_data_d  = op_legal(s1_op_q) ? alu_result : '0;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_id_q     <= 1'b0;
            s1_tag_q    <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_tag_q   <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_id_q     <= s1_id_d;
            s1_tag_q    <= s1_tag_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        alu_add  = 1'b0;
        alu_sub  = 1'b0;
        alu_and  = 1'b0;
        alu_or   = 1'b0;
        alu_sll  = 1'b0;
        alu_sra  = 1'b0;
        alu_addi = 1'b0;
        alu_lw   = 1'b0;
        alu_sw   = 1'b0;
        alu_br   = 1'b0;
        if (s1_valid_q) begin
            case (s1_op_q)
                OP_ADD:  alu_add  = 1'b1;
                OP_SUB:  alu_sub  = 1'b1;
                OP_AND:  alu_and  = 1'b1;
                OP_OR:   alu_or   = 1'b1;
                OP_SLL:  alu_sll  = 1'b1;
                OP_SRA:  alu_sra  = 1'b1;
                OP_ADDI: alu_addi = 1'b1;
                OP_LW:   alu_lw   = 1'b1;
                OP_SW:   alu_sw   = 1'b1;
                OP_BR:   alu_br   = 1'b1;
                default: ;
            endcase
        end
    end

    assign alu_a     = s1_a_q;
    assign alu_b     = s1_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_tag   = rsp_tag_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Randomized bench for alu_issue_arbiter: an ALU environment model plus a transaction-queue reference.
module tb_alu_issue_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_op, req1_op, req0_tag, req1_tag;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [31:0] alu_a, alu_b, alu_result, rsp_data;
    logic        alu_add, alu_sub, alu_addi, alu_and, alu_or;
    logic        alu_sll, alu_sra, alu_sw, alu_lw, alu_br;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [3:0]  rsp_tag;

    always #5 clk = ~clk;

    alu_issue_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
        .alu_a(alu_a), .alu_b(alu_b),
        .alu_add(alu_add), .alu_sub(alu_sub), .alu_addi(alu_addi), .alu_and(alu_and),
        .alu_or(alu_or), .alu_sll(alu_sll), .alu_sra(alu_sra), .alu_sw(alu_sw),
        .alu_lw(alu_lw), .alu_br(alu_br), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_tag(rsp_tag), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    // Control vector indexed by op code.
    logic [9:0]  ctrl;
    logic [31:0] alu_hold = 32'hDEAD_BEEF;
    assign ctrl = {alu_br, alu_sw, alu_lw, alu_addi, alu_sra, alu_sll,
                   alu_or, alu_and, alu_sub, alu_add};

    function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [31:0] a, b);
        case (op)
            4'd0, 4'd6, 4'd7, 4'd8, 4'd9: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a << b[4:0];
            4'd5: return $unsigned($signed(a) >>> b[4:0]);
            default: return 32'h0;
        endcase
    endfunction

    // Environment ALU: keeps its previous output when no control fires.
    always_comb begin
        alu_result = alu_hold;
        for (int k = 0; k < 10; k++) begin
            if (ctrl[k]) alu_result = ref_op(4'(k), alu_a, alu_b);
        end
    end
    always @(posedge clk) if (|ctrl) alu_hold <= alu_result;

    typedef struct {
        bit          id;
        logic [3:0]  tag;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } txn_t;

    txn_t q[$];
    int   vis;
    int   lg;
    bit   pv[2];
    txn_t pt[2];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic load(input int p, input logic [3:0] op, input logic [31:0] a, b,
                        input logic [3:0] tag);
        pv[p]    = 1'b1;
        pt[p].id = p[0];
        pt[p].op = op;
        pt[p].a  = a;
        pt[p].b  = b;
        pt[p].tag = tag;
    endtask

    task automatic model_clear();
        q.delete();
        vis = 0;
        lg  = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_ctrl", 32'(ctrl), 32'h0);
        chk("rst_alu_a", alu_a, 32'h0);
        chk("rst_alu_b", alu_b, 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_rsp_tag", 32'(rsp_tag), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic step(input bit rr);
        bit   s1_occ, s2_free, s1_free, legal;
        int   g;
        txn_t h;
        @(negedge clk);
        req0_valid = pv[0]; req0_op = pt[0].op; req0_a = pt[0].a;
        req0_b = pt[0].b;   req0_tag = pt[0].tag;
        req1_valid = pv[1]; req1_op = pt[1].op; req1_a = pt[1].a;
        req1_b = pt[1].b;   req1_tag = pt[1].tag;
        rsp_ready = rr;
        #1;
        // Two-slot elastic pipe: vis marks whether the head sits in the response slot.
        s1_occ  = q.size() > vis;
        s2_free = (vis == 0) || rr;
        s1_free = !s1_occ || s2_free;
`ifdef ALU_ARB_FIXED_PRIO_EN
        if (pv[0]) g = 0; else if (pv[1]) g = 1; else g = -1;
`else
        if (pv[0] && pv[1]) g = (lg == 0) ? 1 : 0;
        else if (pv[0]) g = 0;
        else if (pv[1]) g = 1;
        else g = -1;
`endif
        if (g >= 0) begin
            chk("req0_ready", 32'(req0_ready), 32'((g == 0) && s1_free));
            chk("req1_ready", 32'(req1_ready), 32'((g == 1) && s1_free));
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(vis));
        if (vis != 0) begin
            h = q[0];
            legal = h.op < 4'd10;
            chk("rsp_id", 32'(rsp_id), 32'(h.id));
            chk("rsp_tag", 32'(rsp_tag), 32'(h.tag));
            chk("rsp_err", 32'(rsp_err), 32'(!legal));
            chk("rsp_data", rsp_data, legal ? ref_op(h.op, h.a, h.b) : 32'h0);
        end
        if (s1_occ) begin
            h = q[vis];
            chk("alu_ctrl", 32'(ctrl), (h.op < 4'd10) ? (32'h1 << h.op) : 32'h0);
            chk("alu_a", alu_a, h.a);
            chk("alu_b", alu_b, h.b);
        end else begin
            chk("alu_ctrl_idle", 32'(ctrl), 32'h0);
        end
        if (vis != 0 && rr) begin
            void'(q.pop_front());
            vis = 0;
        end
        if (s1_occ && vis == 0) vis = 1;
        if (g >= 0 && s1_free) begin
            q.push_back(pt[g]);
            lg = g;
            pv[g] = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 12; i++) step(1'b1);
    endtask

    initial begin
        logic [3:0]  bp_op [4];
        logic [31:0] bp_a  [4];
        int          bp_n;
        reset = 1'b1;
        req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        req0_op = 0; req0_a = 0; req0_b = 0; req0_tag = 0;
        req1_op = 0; req1_a = 0; req1_b = 0; req1_tag = 0;
        pv[0] = 0; pv[1] = 0;
        pt[0] = '{default: 0};
        pt[1] = '{default: 0};
        model_clear();
        do_reset();

        // Single ADD on port 0.
        load(0, 4'd0, 32'd5, 32'd3, 4'd2);
        drain();

        // Continuous contention, responses always drained.
        for (int i = 0; i < 8; i++) begin
            if (!pv[0]) load(0, 4'd1, 32'd10, 32'd4, 4'(i));
            if (!pv[1]) load(1, 4'd7, 32'h100, 32'h20, 4'(i + 8));
            step(1'b1);
        end
        pv[0] = 0; pv[1] = 0;
        drain();

        // Four-op stream against a stalled consumer.
        bp_op = '{4'd2, 4'd3, 4'd5, 4'd8};
        bp_a  = '{32'hF0F0_1234, 32'h0F00_0001, 32'h8000_0000, 32'h44};
        bp_n  = 0;
        for (int i = 0; i < 14; i++) begin
            if (!pv[0] && bp_n < 4) begin
                load(0, bp_op[bp_n], bp_a[bp_n], 32'h0000_0F04, 4'(bp_n));
                bp_n++;
            end
            step(i >= 3);
        end

        // Illegal op on port 1, then shift-amount masking.
        load(1, 4'hF, 32'h77, 32'h99, 4'd5);
        drain();
        load(0, 4'd4, 32'd1, 32'h21, 4'd3);
        drain();

        // Reset with both stages occupied, then a tie must go to port 0.
        load(0, 4'd0, 32'd1, 32'd2, 4'd1);
        load(1, 4'd6, 32'd3, 32'd4, 4'd2);
        for (int i = 0; i < 3; i++) step(1'b0);
        pv[0] = 0; pv[1] = 0;
        do_reset();
        load(0, 4'd9, 32'h1000, 32'h40, 4'd6);
        load(1, 4'd8, 32'h2000, 32'h8, 4'd7);
        drain();

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pv[p] && $urandom_range(0, 99) < 60) begin
                    load(p, ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                        : 4'($urandom_range(0, 9)),
                         $urandom(), ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 63)),
                         4'($urandom()));
                end
            end
            step($urandom_range(0, 99) < 70);
            if (i % 700 == 699) do_reset();
        end
        pv[0] = 0; pv[1] = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
- Shares the single combinational ALU between two requesters: port 0 (execute stage: R-type, ADDI, branch target) and port 1 (load/store address generation).
- Arbitrates round-robin with valid/ready handshakes and registers the winner into an issue stage that drives the ALU's one-hot control lines and operands.
- Captures the ALU result into a response register with valid/ready backpressure.
- Fully pipelined: 1 op/cycle throughput, 2-cycle latency.

Parameters:
- DATA_W, 32, operand/result width (ALU is fixed at 32; other values unsupported).
- OP_W, 4, op code width.
- TAG_W, 4, requester-supplied tag returned with the result.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- reqN_valid  in  1  request valid (N = 0, 1).
- reqN_ready  out  1  request accepted this cycle when valid&ready.
- reqN_op  in  OP_W  op code.
- reqN_a  in  DATA_W  operand A.
- reqN_b  in  DATA_W  operand B.
- reqN_tag  in  TAG_W  tag.
- alu_a  out  DATA_W  to ALU A input.
- alu_b  out  DATA_W  to ALU B input.
- alu_add, alu_sub, alu_addi, alu_and, alu_or, alu_sll, alu_sra, alu_sw, alu_lw, alu_br  out  1 each  one-hot ALU controls.
- alu_result  in  DATA_W  ALU output.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts.
- rsp_id  out  1  requester index.
- rsp_tag  out  TAG_W  echoed tag.
- rsp_data  out  DATA_W  result.
- rsp_err  out  1  illegal op.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Op encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SRA, 6 ADDI, 7 LW, 8 SW, 9 BR. Codes 10–15 are illegal.
- Reset values: all valids 0; all alu_* controls 0; alu_a, alu_b, rsp_data, rsp_tag, rsp_id, rsp_err all 0; last_grant = 1, so port 0 wins the first tie.
- Stage S1 (issue register): holds s1_valid, op, id, tag, a, b.
  - alu_a/alu_b are driven directly from S1 registers.
  - Exactly one control is asserted, decoded from s1_op, only while s1_valid and the op is legal. Otherwise all controls are 0.
  - alu_a/alu_b hold their last value when S1 is empty.
- Stage S2 (response register): on advance, captures alu_result, or 0 with rsp_err=1 for an illegal op.
  - The ALU latches its previous value when no control is asserted, so it must never be sampled for illegal ops.
- Flow control:
  - s2_free = !rsp_valid | rsp_ready.
  - S1→S2 advance = s1_valid & s2_free.
  - s1_free = !s1_valid | s2_free.
  - reqN_ready = grantN & s1_free.
  - S1 loads on any accepted request. It clears when it advances and no new request is accepted.
  - S2 loads on advance. It clears on rsp_ready with no advance.
- Arbitration (combinational):
  - Only one port valid: that port is granted.
  - Both valid: grant the port != last_grant.
  - last_grant updates only on an accepted handshake.
- Latency: request accepted at edge N → ALU controls valid during cycle N+1 → rsp_valid high after edge N+1.
- Ordering: responses are in acceptance order; no reordering.
- Stability: while rsp_valid & !rsp_ready, all rsp_* outputs are held stable.
- Simultaneous events: S2 drain and S1 advance in the same cycle are allowed (full throughput).
- Reset mid-operation: in-flight S1/S2 contents are discarded and no response is produced.
- Requester rules: must hold op/a/b/tag stable while valid & !ready. Withdrawing valid is permitted but the op is then lost.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: strict priority to port 0 when both are valid; last_grant is unused. Port 1 may starve — intended for bring-up.
- Undefined: round-robin as specified above.

Decomposition:
- Shared package alu_arb_pkg holds:
  - OP_W and the op code localparams (OP_ADD … OP_BR);
  - the illegal-op threshold;
  - NUM_REQ=2.
- Natural sub-module rr_arb2: 2-way grant logic with a last_grant register and update-on-accept input. The fixed-priority macro is applied inside it.
- Op-to-one-hot decode stays inline.

Test Plan:
- Single op: req0 ADD a=5 b=3 tag=2, port 1 idle → req0_ready=1 same cycle; alu_add=1 next cycle; rsp_valid, rsp_data=8, rsp_id=0, rsp_tag=2 two cycles after acceptance.
- Contention: both ports valid continuously (req0 SUB 10,4; req1 LW 0x100,0x20), rsp_ready=1 → grants alternate 0,1,0,1; rsp_data alternates 6 and 0x120, one per cycle.
- Backpressure: 4-op stream with rsp_ready=0 for 3 cycles → two ops accepted, then reqN_ready=0; rsp_* held stable; after release all 4 responses arrive in order with none lost.
- Illegal op: req1 op=4'hF → no alu_* control asserted; rsp_err=1, rsp_data=0, rsp_id=1.
- Shift amount: req0 SLL a=1 b=0x21 → rsp_data=2 (only b[4:0] used).
- Reset mid-flight: reset with S1 and S2 both full → rsp_valid=0 next cycle; no stale response. Then both ports valid → port 0 granted first.
- Macro build with ALU_ARB_FIXED_PRIO_EN: both ports valid → only port 0 granted.
